// File: rtl/grad_update.sv
// grad_update -- backward-path weight update for one feature/weight pair.
//
// Per sample: err = predicted - target, grad = 2*err*feature,
// weight -= grad >>> LR_SHIFT, with the new weight saturated to W_WIDTH.
// The err*feature product is built bit-serially, one feature bit per cycle.
//
// Build option: define GRAD_CLIP_EN to clamp delta to [-CLIP_MAG, CLIP_MAG]
// before the subtraction. Without it CLIP_MAG has no effect.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   en_i         global enable; low freezes FSM and all registers
//   start_i      sample strobe, accepted only in IDLE
//   target_i     unsigned target label
//   predicted_i  signed prediction
//   feature_i    unsigned feature paired with this weight
//   wload_i      weight preload strobe, accepted only in IDLE (wins over start_i)
//   wdata_i      signed weight preload value
//   weight_o     current signed weight
//   err_o        signed error latched for the current sample
//   busy_o       high while a sample is in flight
//   done_o       one-cycle pulse on the edge weight_o takes its new value
//
// state | meaning
// IDLE  | waiting for wload_i / start_i
// LOAD  | form err from captured inputs, clear accumulator and bit counter
// MUL   | one feature bit per cycle: acc += err << cnt when bit set
// UPD   | phase 0: register saturated new weight; phase 1: commit, pulse done
module grad_update #(
    parameter int                        W_WIDTH    = 16,
    parameter int                        FEAT_WIDTH = 8,
    parameter int                        LR_SHIFT   = 10,
    parameter logic signed [W_WIDTH-1:0] W_INIT     = '0,
    parameter int                        CLIP_MAG   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic [3:0]                  target_i,
    input  logic signed [22:0]          predicted_i,
    input  logic [FEAT_WIDTH-1:0]       feature_i,
    input  logic                        wload_i,
    input  logic signed [W_WIDTH-1:0]   wdata_i,
    output logic signed [W_WIDTH-1:0]   weight_o,
    output logic signed [23:0]          err_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int CNT_W = (FEAT_WIDTH > 1) ? $clog2(FEAT_WIDTH) : 1;
    localparam int WX    = W_WIDTH + 34;

`ifdef GRAD_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    localparam logic signed [32:0]    CLIP_POS = 33'(CLIP_MAG);
    localparam logic signed [32:0]    CLIP_NEG = -CLIP_POS;
    localparam logic signed [WX-1:0]  W_MAX    = {{(WX-W_WIDTH+1){1'b0}}, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [WX-1:0]  W_MIN    = {{(WX-W_WIDTH+1){1'b1}}, {(W_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FEAT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MUL, UPD} state_t;

    state_t                     state_q, state_d;
    logic signed [W_WIDTH-1:0]  weight_q, weight_d;
    logic signed [W_WIDTH-1:0]  wnew_q, wnew_d;
    logic signed [23:0]         err_q, err_d;
    logic signed [32:0]         acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [22:0]         pred_q, pred_d;
    logic [3:0]                 tgt_q, tgt_d;
    logic [FEAT_WIDTH-1:0]      feat_q, feat_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       upd_ph_q, upd_ph_d;

    logic signed [23:0]         err_c;
    logic signed [32:0]         err_ext_c, partial_c, grad_c, delta_c, delta_clip_c;
    logic signed [WX-1:0]       diff_c;
    logic signed [W_WIDTH-1:0]  wnew_c;

    assign err_c     = $signed({pred_q[22], pred_q}) - $signed({20'd0, tgt_q});
    assign err_ext_c = {{9{err_q[23]}}, err_q};
    assign partial_c = err_ext_c <<< cnt_q;
    assign grad_c    = acc_q <<< 1;
    assign delta_c   = grad_c >>> LR_SHIFT;

    always_comb begin
        delta_clip_c = delta_c;
        if (CLIP_ON) begin
            if (delta_c > CLIP_POS)
                delta_clip_c = CLIP_POS;
            else if (delta_c < CLIP_NEG)
                delta_clip_c = CLIP_NEG;
        end
    end

    // Wide enough that the subtraction itself can never wrap.
    assign diff_c = $signed({{(WX-W_WIDTH){weight_q[W_WIDTH-1]}}, weight_q})
                  - $signed({{(WX-33){delta_clip_c[32]}}, delta_clip_c});

    always_comb begin
        wnew_c = diff_c[W_WIDTH-1:0];
        if (diff_c > W_MAX)
            wnew_c = W_MAX[W_WIDTH-1:0];
        else if (diff_c < W_MIN)
            wnew_c = W_MIN[W_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        wnew_d   = wnew_q;
        err_d    = err_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pred_d   = pred_q;
        tgt_d    = tgt_q;
        feat_d   = feat_q;
        busy_d   = busy_q;
        done_d   = done_q;
        upd_ph_d = upd_ph_q;
        if (en_i) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (wload_i) begin
                        weight_d = wdata_i;
                    end else if (start_i) begin
                        pred_d  = predicted_i;
                        tgt_d   = target_i;
                        feat_d  = feature_i;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    err_d   = err_c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
                MUL: begin
                    if (feat_q[cnt_q])
                        acc_d = acc_q + partial_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        upd_ph_d = 1'b0;
                        state_d  = UPD;
                    end
                end
                UPD: begin
                    // Saturated result is registered first so the wide
                    // subtract/compare has a full cycle before the commit.
                    if (!upd_ph_q) begin
                        wnew_d   = wnew_c;
                        upd_ph_d = 1'b1;
                    end else begin
                        weight_d = wnew_q;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        upd_ph_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            weight_q <= W_INIT;
            wnew_q   <= '0;
            err_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pred_q   <= '0;
            tgt_q    <= '0;
            feat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            upd_ph_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            wnew_q   <= wnew_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pred_q   <= pred_d;
            tgt_q    <= tgt_d;
            feat_q   <= feat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            upd_ph_q <= upd_ph_d;
        end
    end

    assign weight_o = weight_q;
    assign err_o    = err_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_grad_update.sv
// Self-checking bench for grad_update (W_WIDTH=16, FEAT_WIDTH=8, LR_SHIFT=4).
// Expected weight/err/completion cycle are queued when a sample is started
// and compared when done_o pulses.
module tb_grad_update;

    localparam int  W_WIDTH    = 16;
    localparam int  FEAT_WIDTH = 8;
    localparam int  LR_SHIFT   = 4;
    localparam int  CLIP_MAG   = 256;
    localparam int  LAT        = FEAT_WIDTH + 3;

    logic                       clk;
    logic                       rst_i;
    logic                       en_i;
    logic                       start_i;
    logic [3:0]                 target_i;
    logic signed [22:0]         predicted_i;
    logic [FEAT_WIDTH-1:0]      feature_i;
    logic                       wload_i;
    logic signed [W_WIDTH-1:0]  wdata_i;
    logic signed [W_WIDTH-1:0]  weight_o;
    logic signed [23:0]         err_o;
    logic                       busy_o;
    logic                       done_o;

    grad_update #(
        .W_WIDTH    (W_WIDTH),
        .FEAT_WIDTH (FEAT_WIDTH),
        .LR_SHIFT   (LR_SHIFT),
        .W_INIT     ('0),
        .CLIP_MAG   (CLIP_MAG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .start_i     (start_i),
        .target_i    (target_i),
        .predicted_i (predicted_i),
        .feature_i   (feature_i),
        .wload_i     (wload_i),
        .wdata_i     (wdata_i),
        .weight_o    (weight_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    typedef struct {
        longint w;
        longint err;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    longint w_model = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model_w(input longint w, input longint pred,
                                       input longint tgt, input longint feat);
        longint err, grad, delta, wn;
        err   = pred - tgt;
        grad  = 2 * err * feat;
        delta = grad >>> LR_SHIFT;
`ifdef GRAD_CLIP_EN
        if (delta > CLIP_MAG)  delta = CLIP_MAG;
        if (delta < -CLIP_MAG) delta = -CLIP_MAG;
`endif
        wn = w - delta;
        if (wn > 32767)  wn = 32767;
        if (wn < -32768) wn = -32768;
        return wn;
    endfunction

    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("weight", $signed(weight_o), e.w);
                check("err", $signed(err_o), e.err);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic load_weight(input longint v);
        @(negedge clk);
        wload_i = 1'b1;
        wdata_i = 16'(v);
        @(negedge clk);
        wload_i = 1'b0;
        w_model = v;
        check("wload", $signed(weight_o), v);
    endtask

    // Drives start for one edge; returns at the negedge after the start edge.
    task automatic start_sample(input longint pred, input longint tgt, input longint feat,
                                input int extra, input bit expect_done);
        exp_t e;
        @(negedge clk);
        predicted_i = 23'(pred);
        target_i    = 4'(tgt);
        feature_i   = 8'(feat);
        start_i     = 1'b1;
        if (expect_done) begin
            w_model = model_w(w_model, pred, tgt, feat);
            e.w   = w_model;
            e.err = pred - tgt;
            e.cyc = cyc + 1 + LAT + extra;
            sb.push_back(e);
        end
        @(negedge clk);
        start_i     = 1'b0;
        predicted_i = -23'sd1000;
        target_i    = 4'd7;
        feature_i   = 8'hAA;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b0; en_i = 1'b1; start_i = 1'b0; wload_i = 1'b0;
        target_i = '0; predicted_i = '0; feature_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk);
        check("rst_weight", $signed(weight_o), 0);
        check("rst_err", $signed(err_o), 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst_i = 1'b1;

        // basic sample, latency and capture
        start_sample(10, 2, 3, 0, 1'b1);
        check("busy_in_load", busy_o, 1);
        wait_drain();

        // negative error
        load_weight(0);
        start_sample(0, 5, 16, 0, 1'b1);
        wait_drain();

        // saturation both ends
        load_weight(16'sh7FF0);
        start_sample(0, 15, 255, 0, 1'b1);
        wait_drain();
        load_weight(-32763);
        start_sample(15, 0, 255, 0, 1'b1);
        wait_drain();

        // large delta, clip-dependent
        load_weight(0);
        start_sample(0, 15, 255, 0, 1'b1);
        wait_drain();
`ifdef GRAD_CLIP_EN
        check("clip_result", $signed(weight_o), 256);
`else
        check("noclip_result", $signed(weight_o), 479);
`endif

        // feature zero still completes with no change
        start_sample(-100, 3, 0, 0, 1'b1);
        wait_drain();

        // requests while busy are ignored
        load_weight(0);
        start_sample(10, 2, 3, 0, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            start_i     = busy_o;
            wload_i     = busy_o;
            wdata_i     = 16'sh1234;
            predicted_i = 23'sd77;
            feature_i   = 8'hFF;
            @(negedge clk);
            #1;
        end
        start_i = 1'b0;
        wload_i = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("hold_after_busy", $signed(weight_o), w_model);
        check("idle_after_busy", busy_o, 0);

        // start + wload together in IDLE: load only
        @(negedge clk);
        start_i = 1'b1; wload_i = 1'b1; wdata_i = 16'sh0055;
        @(negedge clk);
        start_i = 1'b0; wload_i = 1'b0;
        w_model = 16'sh0055;
        check("both_load", $signed(weight_o), 16'sh0055);
        for (int i = 0; i < 3; i++) begin
            check("both_no_run", busy_o, 0);
            @(negedge clk);
        end

        // reset at MUL cycle 3 aborts the sample
        start_sample(10, 2, 3, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        w_model = 0;
        check("abort_busy", busy_o, 0);
        check("abort_weight", $signed(weight_o), 0);
        check("abort_err", $signed(err_o), 0);
        repeat (16) @(negedge clk);
        check("abort_weight_later", $signed(weight_o), 0);

        // enable low for 5 cycles mid-MUL stretches latency only
        start_sample(10, 2, 3, 5, 1'b1);
        repeat (2) @(negedge clk);
        en_i = 1'b0;
        repeat (2) @(negedge clk);
        check("freeze_busy", busy_o, 1);
        check("freeze_weight", $signed(weight_o), 0);
        repeat (3) @(negedge clk);
        en_i = 1'b1;
        wait_drain();
        check("freeze_result", $signed(weight_o), -3);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
